// File: rtl/ram2_arb_pkg.sv
// Shared definitions for the Ram2 arbiter: state encoding, default widths
// and the pin levels used whenever the SRAM is deselected.
package ram2_arb_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  // Idle (deselected) levels for the active-low SRAM control pins.
  localparam logic IDLE_EN = 1'b1;
  localparam logic IDLE_OE = 1'b1;
  localparam logic IDLE_WE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_MRD    = 3'd2,
    S_WSETUP = 3'd3,
    S_WPULSE = 3'd4,
    S_WHOLD  = 3'd5
  } state_e;

  // States at whose closing edge a new request may be granted.
  function automatic logic is_arb_state(input state_e s);
    return (s == S_IDLE) || (s == S_FETCH) || (s == S_MRD) || (s == S_WHOLD);
  endfunction

endpackage

// File: rtl/ram2_arbiter.sv
// Ram2 SRAM port arbiter: shares the single Ram2 port between instruction
// fetch and MEM-stage accesses. MEM wins over IF. Reads take one cycle.
// Writes take three cycles (setup, WE pulse, hold) when the macro
// RAM2_ARB_WRITE_EN is defined. Without it, program memory is read-only:
// a write grant goes straight to WHOLD without touching the SRAM.
// Owns the Ram2Data tristate driver.
module ram2_arbiter
  import ram2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  output logic              stall_if,
  // MEM stage side
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  // SRAM pins
  output logic [ADDR_W-1:0] Ram2Addr,
  inout  wire  [DATA_W-1:0] Ram2Data,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic              Ram2EN
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              bus_drive;

`ifdef RAM2_ARB_WRITE_EN
  logic [DATA_W-1:0] wdata_q, wdata_d;
`else
  // Write data has no destination in the read-only build.
  logic unused_wdata;
  assign unused_wdata = ^mem_wdata;
`endif

  // Next-state, grant and address/data capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
`ifdef RAM2_ARB_WRITE_EN
    wdata_d = wdata_q;
`endif
    if (is_arb_state(state_q)) begin
      if (mem_req) begin
        addr_d = mem_addr;
        if (mem_we) begin
`ifdef RAM2_ARB_WRITE_EN
          wdata_d = mem_wdata;
          state_d = S_WSETUP;
`else
          state_d = S_WHOLD;
`endif
        end else begin
          state_d = S_MRD;
        end
      end else if (if_req) begin
        addr_d  = if_addr;
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      unique case (state_q)
`ifdef RAM2_ARB_WRITE_EN
        S_WSETUP: state_d = S_WPULSE;
        S_WPULSE: state_d = S_WHOLD;
`endif
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State, address and write-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
`ifdef RAM2_ARB_WRITE_EN
      wdata_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef RAM2_ARB_WRITE_EN
      wdata_q <= wdata_d;
`endif
    end
  end

  // Pin decode from the registered state; reset forces the idle levels at once.
  always_comb begin
    Ram2EN    = IDLE_EN;
    Ram2OE    = IDLE_OE;
    Ram2WE    = IDLE_WE;
    bus_drive = 1'b0;
    unique case (state_q)
      S_FETCH, S_MRD: begin
        Ram2EN = 1'b0;
        Ram2OE = 1'b0;
      end
`ifdef RAM2_ARB_WRITE_EN
      S_WSETUP, S_WHOLD: begin
        Ram2EN    = 1'b0;
        bus_drive = 1'b1;
      end
      S_WPULSE: begin
        Ram2EN    = 1'b0;
        Ram2WE    = 1'b0;
        bus_drive = 1'b1;
      end
`else
      S_WHOLD: begin
        // Read-only build: the chip is selected, but WE stays high and the bus floats.
        Ram2EN = 1'b0;
      end
`endif
      default: ;
    endcase
  end

`ifdef RAM2_ARB_WRITE_EN
  assign Ram2Data = bus_drive ? wdata_q : {DATA_W{1'bz}};
`else
  logic unused_drive;
  assign unused_drive = bus_drive;
  assign Ram2Data     = {DATA_W{1'bz}};
`endif

  assign Ram2Addr  = addr_q;
  assign if_instr  = Ram2Data;
  assign mem_rdata = Ram2Data;
  assign if_valid  = (state_q == S_FETCH);
  assign mem_done  = (state_q == S_MRD) || (state_q == S_WHOLD);
  assign stall_if  = if_req && (state_q != S_FETCH);

endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter with a behavioural async SRAM on the
// Ram2 pins. Expected completions are queued when a request is driven and
// popped when if_valid or mem_done appears. Write-path expectations follow
// RAM2_ARB_WRITE_EN.
module tb_ram2_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_instr;
  logic          if_valid;
  logic          stall_if;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic [AW-1:0] ram2_addr;
  wire  [DW-1:0] ram2_data;
  logic          ram2_oe;
  logic          ram2_we;
  logic          ram2_en;

  ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_instr  (if_instr),
    .if_valid  (if_valid),
    .stall_if  (stall_if),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .Ram2Addr  (ram2_addr),
    .Ram2Data  (ram2_data),
    .Ram2OE    (ram2_oe),
    .Ram2WE    (ram2_we),
    .Ram2EN    (ram2_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus while selected with OE low and
  // stores whatever is on the bus while WE is low.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  assign ram2_data = (!ram2_en && !ram2_oe) ? sram[ram2_addr] : {DW{1'bz}};
  always @(negedge clk) if (!ram2_en && !ram2_we) sram[ram2_addr] = ram2_data;

  // Count of cycles with WE low, sampled mid-cycle.
  int we_low_cnt = 0;
  always @(negedge clk) if (!ram2_we) we_low_cnt++;

  typedef struct {
    string         tag;
    logic          is_fetch;
    logic          chk_data;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int we_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic is_fetch, input logic chk_data,
                          input logic [DW-1:0] data);
    exp_t e;
    e.tag = tag; e.is_fetch = is_fetch; e.chk_data = chk_data; e.data = data;
    exp_q.push_back(e);
  endtask

  // Wait for mid-cycle, check OE/WE exclusivity and retire any completion.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    check("oe_we_both_low", {31'd0, (!ram2_oe && !ram2_we)}, 32'd0);
    if (if_valid || mem_done) begin
      check("scoreboard_has_entry", (exp_q.size() == 0) ? 32'd0 : 32'd1, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_kind"}, {31'd0, if_valid}, {31'd0, e.is_fetch});
        if (e.chk_data)
          check(e.tag, {16'd0, (e.is_fetch ? if_instr : mem_rdata)}, {16'd0, e.data});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    sram[18'h00010] = 16'h1111;
    sram[18'h00011] = 16'h2222;
    sram[18'h00012] = 16'h3333;
    sram[18'h00013] = 16'h4444;
    sram[18'h00100] = 16'hBEEF;
    sram[18'h00300] = 16'hC3C3;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr",     {14'd0, ram2_addr}, 32'd0);
    check("rst_en",       {31'd0, ram2_en},   32'd1);
    check("rst_oe",       {31'd0, ram2_oe},   32'd1);
    check("rst_we",       {31'd0, ram2_we},   32'd1);
    check("rst_if_valid", {31'd0, if_valid},  32'd0);
    check("rst_mem_done", {31'd0, mem_done},  32'd0);
    check("rst_stall_hi", {31'd0, stall_if},  32'd1);
    if_req = 1'b0;
    #1 check("rst_stall_lo", {31'd0, stall_if}, 32'd0);
    #1 rst = 1'b1;

    // ---- back-to-back fetches 0x10..0x12 ----
    @(posedge clk); #1 if_req = 1'b1; if_addr = 18'h00010;
    push_exp("fetch_10", 1'b1, 1'b1, 16'h1111);
    sample();
    check("stall_before_first", {31'd0, stall_if}, 32'd1);
    @(posedge clk); #1 if_addr = 18'h00011;
    push_exp("fetch_11", 1'b1, 1'b1, 16'h2222);
    sample();
    check("stall_fetch_10", {31'd0, stall_if}, 32'd0);
    @(posedge clk); #1 if_addr = 18'h00012;
    push_exp("fetch_12", 1'b1, 1'b1, 16'h3333);
    sample();
    check("stall_fetch_11", {31'd0, stall_if}, 32'd0);

    // ---- MEM read at 0x100 collides with fetch of 0x13: MEM wins ----
    @(posedge clk); #1 if_addr = 18'h00013;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00100;
    push_exp("mrd_100", 1'b0, 1'b1, 16'hBEEF);
    push_exp("fetch_13_resume", 1'b1, 1'b1, 16'h4444);
    sample();
    check("stall_fetch_12", {31'd0, stall_if}, 32'd0);
    @(posedge clk); #1 mem_req = 1'b0;
    sample();
    check("stall_during_mrd", {31'd0, stall_if}, 32'd1);
    check("mrd_addr", {14'd0, ram2_addr}, 32'h100);
    @(posedge clk); #1 if_req = 1'b0;
    sample();
    check("stall_after_mrd", {31'd0, stall_if}, 32'd0);
    @(posedge clk); #1;
    sample();
    check("idle_if_valid", {31'd0, if_valid}, 32'd0);
    check("idle_mem_done", {31'd0, mem_done}, 32'd0);
    check("idle_en",       {31'd0, ram2_en},  32'd1);

    we_base = we_low_cnt;
`ifdef RAM2_ARB_WRITE_EN
    // ---- write 0xA5A5 to 0x200, then read it back with no gap ----
    @(posedge clk); #1 mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 18'h00200; mem_wdata = 16'hA5A5;
    push_exp("wr_200", 1'b0, 1'b0, 16'h0000);
    sample();
    @(posedge clk); #1;
    sample();
    check("wsetup_addr", {14'd0, ram2_addr}, 32'h200);
    check("wsetup_data", {16'd0, ram2_data}, 32'hA5A5);
    check("wsetup_we",   {31'd0, ram2_we},   32'd1);
    check("wsetup_oe",   {31'd0, ram2_oe},   32'd1);
    check("wsetup_en",   {31'd0, ram2_en},   32'd0);
    check("wsetup_done", {31'd0, mem_done},  32'd0);
    @(posedge clk); #1;
    sample();
    check("wpulse_we",   {31'd0, ram2_we},   32'd0);
    check("wpulse_addr", {14'd0, ram2_addr}, 32'h200);
    check("wpulse_data", {16'd0, ram2_data}, 32'hA5A5);
    @(posedge clk); #1 mem_we = 1'b0;
    push_exp("rd_after_wr", 1'b0, 1'b1, 16'hA5A5);
    sample();
    check("whold_we",   {31'd0, ram2_we},   32'd1);
    check("whold_addr", {14'd0, ram2_addr}, 32'h200);
    check("whold_data", {16'd0, ram2_data}, 32'hA5A5);
    @(posedge clk); #1 mem_req = 1'b0;
    sample();
    check("mrd_oe_no_gap", {31'd0, ram2_oe}, 32'd0);
    check("we_low_cycles", we_low_cnt - we_base, 32'd1);

    // ---- reset asserted in the middle of WPULSE ----
    @(posedge clk); #1 mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 18'h00210; mem_wdata = 16'h1234;
    sample();
    @(posedge clk); #1;
    sample();
    @(posedge clk); #1;
    check("pre_reset_we_low", {31'd0, ram2_we}, 32'd0);
    rst = 1'b0; mem_req = 1'b0;
    #1;
`else
    // ---- read-only build: write 0x5A5A to 0x300 leaves SRAM untouched ----
    @(posedge clk); #1 mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 18'h00300; mem_wdata = 16'h5A5A;
    push_exp("wr_300_ro", 1'b0, 1'b0, 16'h0000);
    sample();
    @(posedge clk); #1 mem_we = 1'b0;
    push_exp("rd_300_old", 1'b0, 1'b1, 16'hC3C3);
    sample();
    check("ro_whold_we", {31'd0, ram2_we}, 32'd1);
    check("ro_whold_oe", {31'd0, ram2_oe}, 32'd1);
    check("ro_whold_en", {31'd0, ram2_en}, 32'd0);
    @(posedge clk); #1 mem_req = 1'b0;
    sample();
    check("ro_we_never_low", we_low_cnt - we_base, 32'd0);

    // ---- reset asserted in the middle of the read-only WHOLD ----
    @(posedge clk); #1 mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 18'h00310; mem_wdata = 16'h1234;
    sample();
    @(posedge clk); #1;
    check("pre_reset_done", {31'd0, mem_done}, 32'd1);
    rst = 1'b0; mem_req = 1'b0;
    #1;
`endif
    check("midrst_we",   {31'd0, ram2_we},   32'd1);
    check("midrst_en",   {31'd0, ram2_en},   32'd1);
    check("midrst_oe",   {31'd0, ram2_oe},   32'd1);
    check("midrst_addr", {14'd0, ram2_addr}, 32'd0);
    check("midrst_done", {31'd0, mem_done},  32'd0);
    sample();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    sample();
    check("postrst_done",  {31'd0, mem_done}, 32'd0);
    check("postrst_valid", {31'd0, if_valid}, 32'd0);
    check("postrst_en",    {31'd0, ram2_en},  32'd1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram2_arbiter.md
# ram2_arbiter

Shares the single Ram2 SRAM port between instruction fetch (IF stage) and data accesses from the MEM stage that decode to the Ram2 address space. Owns all Ram2 pins and the Ram2Data tristate. Sequences single-cycle reads and three-phase writes. Stalls IF whenever the MEM stage holds the bus. Sits between the pc/IF logic, the EX/MEM register outputs and the Ram2 pins in zzcpu.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- if_req  in  1  IF requests an instruction fetch
- if_addr  in  ADDR_W  fetch address (pc)
- if_instr  out  DATA_W  fetched instruction, valid when if_valid=1
- if_valid  out  1  fetch completes this cycle
- stall_if  out  1  IF must hold pc and insert a bubble into IF/ID
- mem_req  in  1  MEM-stage Ram2 access (is_RAM2 & (read|write)), held until mem_done
- mem_we  in  1  1=write, 0=read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  read data, valid when mem_done=1 and mem_we=0
- mem_done  out  1  MEM access completes this cycle
- Ram2Addr  out  ADDR_W  SRAM address
- Ram2Data  inout  DATA_W  SRAM data bus
- Ram2OE  out  1  output enable, active-low
- Ram2WE  out  1  write enable, active-low
- Ram2EN  out  1  chip enable, active-low

## Operation
- States: IDLE, FETCH, MRD, WSETUP, WPULSE, WHOLD.
- Arbitration happens at a clock edge in IDLE, FETCH, MRD or WHOLD:
  - mem_req=1 goes to MRD (mem_we=0) or WSETUP (mem_we=1). MEM has priority because it holds the older instruction.
  - Otherwise if_req=1 goes to FETCH.
  - Otherwise go to IDLE.
- On grant, the address is latched into the internal addr register; mem_wdata is latched on a write grant.
- Sequencing states: WSETUP goes to WPULSE, then WPULSE goes to WHOLD, unconditionally.
- Pin decode by state:
  - IDLE: EN=1, OE=1, WE=1, bus Z.
  - FETCH, MRD: EN=0, OE=0, WE=1, bus Z.
  - WSETUP, WHOLD: EN=0, OE=1, WE=1, bus driven with latched wdata.
  - WPULSE: EN=0, OE=1, WE=0, bus driven.
- Ram2Addr = latched addr register. It is held unchanged across WSETUP through WHOLD.
- if_instr = mem_rdata = Ram2Data, passed through combinationally.
- if_valid = (state==FETCH).
- mem_done = (state==MRD) | (state==WHOLD).
- stall_if = if_req & (state!=FETCH).
- Requesters advance on the edge that ends a valid/done cycle. A new mem_req present at that edge is granted immediately, so back-to-back MEM accesses have no idle gap.
- Boundary conditions:
  - mem_req and if_req arrive together: MEM wins, stall_if=1 until the MEM access ends.
  - Back-to-back fetches: FETCH stays in FETCH each cycle with the new if_addr latched.
  - mem_req drops before mem_done: this is a protocol violation. The access in flight completes anyway.
  - Reset mid-write: pins go immediately to the IDLE levels. The truncated write is accepted.

## Timing
- Reset values: state IDLE; Ram2Addr=0; Ram2OE=Ram2WE=Ram2EN=1; Ram2Data=Z; if_valid=0; mem_done=0; if_instr and mem_rdata follow the bus; stall_if=if_req.
- Fetch: request sampled at edge k; if_valid=1 in cycle k+1. Sustained throughput is 1 per cycle.
- MEM read: request sampled at edge k; mem_done=1 in cycle k+1.
- MEM write: request sampled at edge k; WSETUP in k+1, WE low in k+2, mem_done in k+3.
- The bus is driven only in write states. OE is never low in the same cycle as a driven bus.

## Configuration
- RAM2_ARB_WRITE_EN:
  - Defined: writes sequence as above.
  - Undefined: program memory is read-only. A write grant goes to WHOLD directly with WE held at 1 and the bus at Z, so mem_done=1 one cycle after grant and the SRAM is untouched. The WSETUP and WPULSE states are not built.

## Structure
- Shared package ram2_arb_pkg holds:
  - the state enum
  - ADDR_W/DATA_W defaults
  - the idle pin constants (EN/OE/WE=1)
- Single module, no sub-module.
- The tristate lives in this module only and is not pushed into zzcpu.

## Test plan
- Reset asserted mid-WPULSE -> Ram2WE=1, Ram2EN=1, bus Z in the same cycle; after release state IDLE, mem_done=0.
- if_req=1 with if_addr stepping 0x00010, 0x00011, 0x00012 and SRAM preloaded 0x1111/0x2222/0x3333 -> if_valid=1 for 3 consecutive cycles with if_instr 0x1111, 0x2222, 0x3333; stall_if=0 after the first.
- if_req and a mem_req read at 0x00100 (=0xBEEF) arriving together -> stall_if=1 one cycle; mem_done=1 with mem_rdata=0xBEEF; fetch resumes next cycle.
- mem_req write 0xA5A5 to 0x00200 -> WE low exactly one cycle; Ram2Addr=0x00200 and data=0xA5A5 stable over 3 cycles; mem_done in 3rd; readback returns 0xA5A5.
- Write immediately followed by a read at the same address -> no idle cycle between WHOLD and MRD; read returns new data.
- Build without RAM2_ARB_WRITE_EN and write 0x5A5A to 0x00300 -> mem_done 1 cycle after grant; Ram2WE never 0; readback returns the old contents.
